// File: rtl/divider_nrs.sv
// Iterative non-restoring divider, signed or unsigned, fixed BITS+3 cycle latency.
// One quotient bit per cycle; signs are stripped before iterating and reapplied in FIX.
module divider_nrs #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_signed,
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            div_by_zero,
    output logic            overflow
);

    localparam int CW = $clog2(BITS);
    localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [BITS-1:0] q_r;
    logic [BITS-1:0] d_r;
    logic [BITS:0]   p_r;
    logic [BITS-1:0] r_r;
    logic [CW-1:0]   cnt_r;
    logic            sgn_r;
    logic            qneg_r;
    logic            rneg_r;
    logic            dz_r;
    logic            ov_r;

    logic [BITS:0] d_ext;
    logic [BITS:0] p_sh;
    logic [BITS:0] p_nx;
    logic [BITS:0] p_fix;

    assign busy  = (state != IDLE);
    assign d_ext = {1'b0, d_r};
    assign p_sh  = {p_r[BITS-1:0], q_r[BITS-1]};
    assign p_nx  = p_r[BITS] ? p_sh + d_ext : p_sh - d_ext;
    assign p_fix = p_r[BITS] ? p_r + d_ext : p_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = PREP;
            PREP: state_nx = ITER;
            ITER: if (cnt_r == LAST) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r         <= '0;
            d_r         <= '0;
            p_r         <= '0;
            r_r         <= '0;
            cnt_r       <= '0;
            sgn_r       <= 1'b0;
            qneg_r      <= 1'b0;
            rneg_r      <= 1'b0;
            dz_r        <= 1'b0;
            ov_r        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        q_r   <= dividend;
                        d_r   <= divisor;
                        sgn_r <= is_signed;
                    end
                end
                PREP: begin
                    q_r    <= (sgn_r && q_r[BITS-1]) ? -q_r : q_r;
                    d_r    <= (sgn_r && d_r[BITS-1]) ? -d_r : d_r;
                    p_r    <= '0;
                    cnt_r  <= '0;
                    rneg_r <= sgn_r && q_r[BITS-1];
                    qneg_r <= sgn_r && (q_r[BITS-1] ^ d_r[BITS-1]);
                    dz_r   <= (d_r == '0);
                    ov_r   <= sgn_r && (q_r == MIN_NEG) && (d_r == '1);
                end
                ITER: begin
                    p_r   <= p_nx;
                    q_r   <= {q_r[BITS-2:0], ~p_nx[BITS]};
                    cnt_r <= cnt_r + CW'(1);
                end
                FIX: begin
                    // A zero divisor leaves |dividend| as remainder; force the quotient.
                    q_r <= dz_r ? '1 : (qneg_r ? -q_r : q_r);
                    r_r <= rneg_r ? -p_fix[BITS-1:0] : p_fix[BITS-1:0];
                end
                DONE: begin
                    quotient    <= q_r;
                    remainder   <= r_r;
                    div_by_zero <= dz_r;
                    overflow    <= ov_r;
                end
                default: ;
            endcase
        end
    end

endmodule
